idex_latch: RTL and testbench

IDEX_LATCH -- requirements
Module: idex_latch

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/lu_detect.sv | 23 ++
 rtl/idex_latch.sv | 142 ++++++++++++++
 tb/tb_idex_latch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: datapath widths, ID/EX payload bundle and the
// ID/EX bubble state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned ALUOP_W      = 4;
    localparam int unsigned BUBBLE_CNT_W = 16;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [REG_W-1:0]   regbits_t;
    typedef logic [ALUOP_W-1:0] aluop_t;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } idex_state_t;

    typedef struct packed {
        logic     valid;
        logic     Reg_write;
        logic     Mem_read;
        logic     Mem_write;
        regbits_t rsel1;
        regbits_t rsel2;
        regbits_t wsel;
        aluop_t   alu_op;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        word_t    pc_next;
    } idex_t;

    // An all-zero bundle is the pipeline NOP.
    localparam idex_t IDEX_NOP = '0;

endpackage

// File: rtl/lu_detect.sv
// Load-use hazard comparator: a valid load in EX whose destination feeds a
// source of the valid instruction in ID.
module lu_detect
    import cpu_types_pkg::*;
(
    input  logic     i_ex_valid,
    input  logic     i_ex_Mem_read,
    input  regbits_t i_ex_wsel,
    input  logic     i_id_valid,
    input  regbits_t i_id_rsel1,
    input  regbits_t i_id_rsel2,
    output logic     o_lu_stall
);

    logic w_dst_live;
    logic w_src_hit;

    // Register 0 never carries a hazard.
    assign w_dst_live = i_ex_valid & i_ex_Mem_read & (i_ex_wsel != REG_W'(0));
    assign w_src_hit  = (i_ex_wsel == i_id_rsel1) | (i_ex_wsel == i_id_rsel2);
    assign o_lu_stall = w_dst_live & w_src_hit & i_id_valid;

endmodule

// File: rtl/idex_latch.sv
// ID/EX pipeline register with flush, load-use bubble insertion and a
// saturating bubble counter.
module idex_latch
    import cpu_types_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    cnt_clr,
    input  logic                    id_valid,
    input  logic                    id_Reg_write,
    input  logic                    id_Mem_read,
    input  logic                    id_Mem_write,
    input  regbits_t                id_rsel1,
    input  regbits_t                id_rsel2,
    input  regbits_t                id_wsel,
    input  aluop_t                  id_alu_op,
    input  word_t                   id_rdat1,
    input  word_t                   id_rdat2,
    input  word_t                   id_imm,
    input  word_t                   id_pc_next,
    output logic                    ex_valid,
    output logic                    ex_Reg_write,
    output logic                    ex_Mem_read,
    output logic                    ex_Mem_write,
    output regbits_t                ex_rsel1,
    output regbits_t                ex_rsel2,
    output regbits_t                ex_wsel,
    output aluop_t                  ex_alu_op,
    output word_t                   ex_rdat1,
    output word_t                   ex_rdat2,
    output word_t                   ex_imm,
    output word_t                   ex_pc_next,
    output logic                    lu_stall,
    output logic                    bubble,
    output logic [BUBBLE_CNT_W-1:0] bubble_count
);

    localparam logic [BUBBLE_CNT_W-1:0] CNT_MAX = '1;

    idex_t                   r_ex;
    idex_state_t             r_state;
    idex_state_t             w_state_next;
    logic [BUBBLE_CNT_W-1:0] r_bubble_count;
    idex_t                   w_id;
    logic                    w_lu_stall;
    logic                    w_insert_bubble;

    assign w_id = '{
        valid:     id_valid,
        Reg_write: id_Reg_write,
        Mem_read:  id_Mem_read,
        Mem_write: id_Mem_write,
        rsel1:     id_rsel1,
        rsel2:     id_rsel2,
        wsel:      id_wsel,
        alu_op:    id_alu_op,
        rdat1:     id_rdat1,
        rdat2:     id_rdat2,
        imm:       id_imm,
        pc_next:   id_pc_next
    };

    lu_detect u_lu_detect (
        .i_ex_valid    (r_ex.valid),
        .i_ex_Mem_read (r_ex.Mem_read),
        .i_ex_wsel     (r_ex.wsel),
        .i_id_valid    (id_valid),
        .i_id_rsel1    (id_rsel1),
        .i_id_rsel2    (id_rsel2),
        .o_lu_stall    (w_lu_stall)
    );

    // A flush outranks the stall, so a squashed slot never counts as a bubble.
    assign w_insert_bubble = ~flush & en & w_lu_stall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = RUN;
        end else if (en && w_lu_stall) begin
            w_state_next = BUBBLE;
        end else if (en) begin
            w_state_next = RUN;
        end
    end

    always_comb begin
        bubble = 1'b0;
        if (r_state == BUBBLE) begin
            bubble = 1'b1;
        end
    end

    // Pipeline payload: NOP on flush or stall, capture on advance, else hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ex <= IDEX_NOP;
        end else if (flush) begin
            r_ex <= IDEX_NOP;
        end else if (en && w_lu_stall) begin
            r_ex <= IDEX_NOP;
        end else if (en) begin
            r_ex <= w_id;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bubble_count <= '0;
        end else if (cnt_clr) begin
            r_bubble_count <= '0;
        end else if (w_insert_bubble && (r_bubble_count != CNT_MAX)) begin
            r_bubble_count <= r_bubble_count + BUBBLE_CNT_W'(1);
        end
    end

    assign ex_valid     = r_ex.valid;
    assign ex_Reg_write = r_ex.Reg_write;
    assign ex_Mem_read  = r_ex.Mem_read;
    assign ex_Mem_write = r_ex.Mem_write;
    assign ex_rsel1     = r_ex.rsel1;
    assign ex_rsel2     = r_ex.rsel2;
    assign ex_wsel      = r_ex.wsel;
    assign ex_alu_op    = r_ex.alu_op;
    assign ex_rdat1     = r_ex.rdat1;
    assign ex_rdat2     = r_ex.rdat2;
    assign ex_imm       = r_ex.imm;
    assign ex_pc_next   = r_ex.pc_next;
    assign lu_stall     = w_lu_stall;
    assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_idex_latch.sv
// Self-checking bench for idex_latch: directed load-use/flush/hold/saturation
// scenarios followed by randomized traffic against a behavioural model.
module tb_idex_latch;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     RST, en, flush, cnt_clr;
    logic     id_valid, id_Reg_write, id_Mem_read, id_Mem_write;
    regbits_t id_rsel1, id_rsel2, id_wsel;
    aluop_t   id_alu_op;
    word_t    id_rdat1, id_rdat2, id_imm, id_pc_next;
    logic     ex_valid, ex_Reg_write, ex_Mem_read, ex_Mem_write;
    regbits_t ex_rsel1, ex_rsel2, ex_wsel;
    aluop_t   ex_alu_op;
    word_t    ex_rdat1, ex_rdat2, ex_imm, ex_pc_next;
    logic     lu_stall, bubble;
    logic [15:0] bubble_count;

    int vecs = 0;
    int errs = 0;
    bit chk_en = 1'b0;

    // Behavioural model: the instruction sitting in EX, bubble flag and count.
    idex_t m_ex;
    bit    m_bub;
    int    m_cnt;

    idex_latch dut (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .cnt_clr(cnt_clr),
        .id_valid(id_valid), .id_Reg_write(id_Reg_write), .id_Mem_read(id_Mem_read),
        .id_Mem_write(id_Mem_write), .id_rsel1(id_rsel1), .id_rsel2(id_rsel2),
        .id_wsel(id_wsel), .id_alu_op(id_alu_op), .id_rdat1(id_rdat1),
        .id_rdat2(id_rdat2), .id_imm(id_imm), .id_pc_next(id_pc_next),
        .ex_valid(ex_valid), .ex_Reg_write(ex_Reg_write), .ex_Mem_read(ex_Mem_read),
        .ex_Mem_write(ex_Mem_write), .ex_rsel1(ex_rsel1), .ex_rsel2(ex_rsel2),
        .ex_wsel(ex_wsel), .ex_alu_op(ex_alu_op), .ex_rdat1(ex_rdat1),
        .ex_rdat2(ex_rdat2), .ex_imm(ex_imm), .ex_pc_next(ex_pc_next),
        .lu_stall(lu_stall), .bubble(bubble), .bubble_count(bubble_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic idex_t id_bundle();
        idex_t b;
        b.valid = id_valid;       b.Reg_write = id_Reg_write;
        b.Mem_read = id_Mem_read; b.Mem_write = id_Mem_write;
        b.rsel1 = id_rsel1;       b.rsel2 = id_rsel2;
        b.wsel = id_wsel;         b.alu_op = id_alu_op;
        b.rdat1 = id_rdat1;       b.rdat2 = id_rdat2;
        b.imm = id_imm;           b.pc_next = id_pc_next;
        return b;
    endfunction

    function automatic idex_t ex_bundle();
        idex_t b;
        b.valid = ex_valid;       b.Reg_write = ex_Reg_write;
        b.Mem_read = ex_Mem_read; b.Mem_write = ex_Mem_write;
        b.rsel1 = ex_rsel1;       b.rsel2 = ex_rsel2;
        b.wsel = ex_wsel;         b.alu_op = ex_alu_op;
        b.rdat1 = ex_rdat1;       b.rdat2 = ex_rdat2;
        b.imm = ex_imm;           b.pc_next = ex_pc_next;
        return b;
    endfunction

    // Hazard: ID reads a nonzero register that a load currently in EX will write.
    function automatic bit m_stall();
        return id_valid && m_ex.valid && m_ex.Mem_read && (m_ex.wsel != 0) &&
               ((m_ex.wsel == id_rsel1) || (m_ex.wsel == id_rsel2));
    endfunction

    task automatic model_edge();
        bit st;
        st = m_stall();
        if (RST) begin
            m_ex = '0; m_bub = 0; m_cnt = 0;
        end else begin
            if (flush) begin
                m_ex = '0; m_bub = 0;
            end else if (en && st) begin
                m_ex = '0; m_bub = 1;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else if (en) begin
                m_ex = id_bundle(); m_bub = 0;
            end
            if (cnt_clr) m_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic set_id(input logic v, input logic mr, input regbits_t r1,
                          input regbits_t r2, input regbits_t w, input word_t d1);
        id_valid = v; id_Reg_write = v; id_Mem_read = mr; id_Mem_write = 1'b0;
        id_rsel1 = r1; id_rsel2 = r2; id_wsel = w; id_alu_op = 4'h3;
        id_rdat1 = d1; id_rdat2 = d1 ^ 32'h0F0F_0F0F; id_imm = 32'h0000_0010;
        id_pc_next = 32'h0000_1004;
    endtask

    // One load-use pair: capture a load writing r8, then present a reader of r8.
    task automatic load_then_use(input logic clr_on_use);
        en = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        set_id(1'b1, 1'b1, 5'd0, 5'd0, 5'd8, 32'h1111_0000);
        tick();
        set_id(1'b1, 1'b0, 5'd8, 5'd2, 5'd9, 32'h2222_0000);
        cnt_clr = clr_on_use;
        tick();
        cnt_clr = 1'b0;
    endtask

    // Continuous comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("ex_bundle", 160'(ex_bundle()), 160'(m_ex));
            chk("lu_stall", 160'(lu_stall), 160'(m_stall()));
            chk("bubble", 160'(bubble), 160'(m_bub));
            chk("bubble_count", 160'(bubble_count), 160'(m_cnt));
        end
    end

    initial begin
        RST = 1'b1; en = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        set_id(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        m_ex = '0; m_bub = 0; m_cnt = 0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset_ex_valid", 160'(ex_valid), 160'(0));
        chk("reset_count", 160'(bubble_count), 160'(0));
        RST = 1'b0;

        // Load then use of r8 through rsel2.
        en = 1'b1;
        set_id(1'b1, 1'b1, 5'd0, 5'd0, 5'd8, 32'h0000_0001);
        tick();
        set_id(1'b1, 1'b0, 5'd3, 5'd8, 5'd4, 32'hDEAD_BEEF);
        #1;
        chk("lu_use_stall", 160'(lu_stall), 160'(1));
        tick();
        chk("lu_bubble", 160'(bubble), 160'(1));
        chk("lu_nop", 160'(ex_valid), 160'(0));
        chk("lu_count1", 160'(bubble_count), 160'(1));
        chk("lu_bubble_stall", 160'(lu_stall), 160'(0));
        tick();
        chk("lu_capture", 160'(ex_rdat1), 160'(32'hDEAD_BEEF));
        chk("lu_run", 160'(bubble), 160'(0));

        // Hold for three cycles.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_rdat1", 160'(ex_rdat1), 160'(32'hDEAD_BEEF));
        end

        // Load to r0 never stalls.
        en = 1'b1;
        set_id(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0);
        tick();
        set_id(1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 32'h1234_5678);
        #1;
        chk("r0_no_stall", 160'(lu_stall), 160'(0));
        tick();
        chk("r0_capture", 160'(ex_rdat1), 160'(32'h1234_5678));
        chk("r0_wsel_latched", 160'(ex_wsel), 160'(5));

        // Flush beats a pending stall with en low.
        set_id(1'b1, 1'b1, 5'd0, 5'd0, 5'd8, 32'h0);
        tick();
        en = 1'b0;
        set_id(1'b1, 1'b0, 5'd8, 5'd0, 5'd1, 32'h5555_5555);
        #1;
        chk("flush_pending_stall", 160'(lu_stall), 160'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_nop", 160'(ex_valid), 160'(0));
        chk("flush_run", 160'(bubble), 160'(0));
        chk("flush_count", 160'(bubble_count), 160'(1));

        // Saturation near the top of the counter.
        force dut.r_bubble_count = 16'hFFFE;
        #1;
        release dut.r_bubble_count;
        m_cnt = 16'hFFFE;
        load_then_use(1'b0);
        chk("sat_first", 160'(bubble_count), 160'(16'hFFFF));
        load_then_use(1'b0);
        chk("sat_hold", 160'(bubble_count), 160'(16'hFFFF));
        load_then_use(1'b1);
        chk("clr_over_inc", 160'(bubble_count), 160'(0));
        chk("clr_bubble", 160'(bubble), 160'(1));

        // Reset while in a bubble.
        load_then_use(1'b0);
        chk("pre_rst_bubble", 160'(bubble), 160'(1));
        RST = 1'b1; flush = 1'b1; cnt_clr = 1'b0;
        tick();
        RST = 1'b0; flush = 1'b0; en = 1'b0;
        chk("rst_bubble", 160'(bubble), 160'(0));
        chk("rst_ex_valid", 160'(ex_valid), 160'(0));
        chk("rst_count", 160'(bubble_count), 160'(0));

        // Randomized traffic on a small register space to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            RST     = ($urandom_range(0, 99) < 2);
            en      = ($urandom_range(0, 99) < 75);
            flush   = ($urandom_range(0, 99) < 10);
            cnt_clr = ($urandom_range(0, 99) < 4);
            id_valid     = ($urandom_range(0, 99) < 85);
            id_Reg_write = 1'($urandom);
            id_Mem_read  = ($urandom_range(0, 99) < 45);
            id_Mem_write = 1'($urandom);
            id_rsel1  = 5'($urandom_range(0, 3));
            id_rsel2  = 5'($urandom_range(0, 3));
            id_wsel   = 5'($urandom_range(0, 3));
            id_alu_op = 4'($urandom);
            id_rdat1  = $urandom; id_rdat2 = $urandom;
            id_imm    = $urandom; id_pc_next = $urandom;
            tick();
        end

        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
